// File: rtl/ts_packet_generator.sv
// ts_packet_generator: MPEG-2 TS packet source with valid/ready byte output.
// Each packet is 188 bytes by default: a 4-byte header carrying the PID and a
// 4-bit continuity counter (cc), followed by a counting payload.
// Optional feature macro: TS_CC_DROP_EN. When it is defined, drop_req makes
// the next packet completion skip one cc value. When it is undefined, drop_req
// is ignored.
module ts_packet_generator #(
    parameter int PACKET_LEN = 188,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [12:0] pid,
    input  logic        drop_req,
    input  logic        ready,
    output logic [7:0]  ts_data,
    output logic        valid,
    output logic        sync,
    output logic [3:0]  cc,
    output logic [31:0] packet_count
);

    localparam int IW = $clog2(PACKET_LEN);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PACKET_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] index_reg, index_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic [12:0]   pid_reg, pid_next;
    logic [3:0]    cc_reg, cc_next;
    logic [31:0]   count_reg, count_next;
    logic [3:0]    cc_step;
    logic          last_xfer;

    // The final byte of the packet is accepted downstream this cycle.
    assign last_xfer = (state_reg == SEND) && ready && (index_reg == LAST_IDX);

`ifdef TS_CC_DROP_EN
    logic drop_pending_reg, drop_pending_next;
    logic drop_active;

    // A pulse that arrives together with the final byte counts for this packet.
    assign drop_active = drop_pending_reg | drop_req;
    assign cc_step     = drop_active ? 4'd2 : 4'd1;

    // Sticky drop request: any number of pulses collapse to one skip.
    always_comb begin
        drop_pending_next = drop_active;
        if (last_xfer) begin
            drop_pending_next = 1'b0;
        end
    end

    // Drop flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_pending_reg <= 1'b0;
        end else begin
            drop_pending_reg <= drop_pending_next;
        end
    end
`else
    logic unused_drop_req;
    assign unused_drop_req = drop_req;
    assign cc_step         = 4'd1;
`endif

    // Next-state logic: the byte index, gap timer, PID latch, cc and packet count.
    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        gap_cnt_next = gap_cnt_reg;
        pid_next     = pid_reg;
        cc_next      = cc_reg;
        count_next   = count_reg;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = SEND;
                    pid_next   = pid;
                    index_next = '0;
                end
            end
            SEND: begin
                if (ready) begin
                    if (index_reg == LAST_IDX) begin
                        index_next = '0;
                        count_next = count_reg + 32'd1;
                        cc_next    = cc_reg + cc_step;
                        if (GAP_CYCLES > 0) begin
                            state_next   = GAP;
                            gap_cnt_next = '0;
                        end else if (enable) begin
                            // The next packet follows back-to-back with a fresh PID.
                            pid_next = pid;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        index_next = index_reg + IW'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    if (enable) begin
                        state_next = SEND;
                        pid_next   = pid;
                        index_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset aborts any packet in flight without counting it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            index_reg   <= '0;
            gap_cnt_reg <= '0;
            pid_reg     <= '0;
            cc_reg      <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            gap_cnt_reg <= gap_cnt_next;
            pid_reg     <= pid_next;
            cc_reg      <= cc_next;
            count_reg   <= count_next;
        end
    end

    logic [IW-1:0] payload_idx;
    assign payload_idx = index_reg - IW'(4);

    // The byte mux is driven from registers only, so the outputs hold while
    // ready is low.
    always_comb begin
        ts_data = 8'h00;
        valid   = 1'b0;
        sync    = 1'b0;
        if (state_reg == SEND) begin
            valid = 1'b1;
            case (index_reg)
                IW'(0): begin
                    ts_data = 8'h47;
                    sync    = 1'b1;
                end
                IW'(1):  ts_data = {3'b000, pid_reg[12:8]};
                IW'(2):  ts_data = pid_reg[7:0];
                IW'(3):  ts_data = {2'b00, 2'b01, cc_reg};
                default: ts_data = 8'(payload_idx);
            endcase
        end
    end

    assign cc           = cc_reg;
    assign packet_count = count_reg;

endmodule

// File: tb/tb_ts_packet_generator.sv
// tb_ts_packet_generator: self-checking bench for ts_packet_generator.
// Two instances share one stimulus stream. dut0 uses a 4-cycle gap and dut1
// runs back-to-back. A transaction-level model predicts every output cycle.
// The TS_CC_DROP_EN macro selects the expected drop behaviour.
module tb_ts_packet_generator;

    localparam int PLEN = 188;
    localparam int GAPV [2] = '{4, 0};

    logic        clk = 1'b0;
    logic        reset, enable, ready, drop_req;
    logic [12:0] pid;

    logic [7:0]  d0_data, d1_data;
    logic        d0_valid, d1_valid, d0_sync, d1_sync;
    logic [3:0]  d0_cc, d1_cc;
    logic [31:0] d0_cnt, d1_cnt;

    always #5 clk = ~clk;

    ts_packet_generator #(.PACKET_LEN(PLEN), .GAP_CYCLES(4)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .pid(pid), .drop_req(drop_req),
        .ready(ready), .ts_data(d0_data), .valid(d0_valid), .sync(d0_sync),
        .cc(d0_cc), .packet_count(d0_cnt)
    );

    ts_packet_generator #(.PACKET_LEN(PLEN), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .pid(pid), .drop_req(drop_req),
        .ready(ready), .ts_data(d1_data), .valid(d1_valid), .sync(d1_sync),
        .cc(d1_cc), .packet_count(d1_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Snapshot of the DUT outputs.
    logic [7:0]  o_data  [2];
    logic        o_valid [2];
    logic        o_sync  [2];
    logic [3:0]  o_cc    [2];
    logic [31:0] o_cnt   [2];

    // Reference model, kept at the packet/byte level.
    bit          m_active [2];
    int          m_idx    [2];
    logic [12:0] m_pid    [2];
    logic [3:0]  m_cc     [2];
    logic [31:0] m_count  [2];
    bit          m_pend   [2];
    int          m_idle   [2];

    logic [7:0]  cap      [PLEN];
    logic        cap_sync [PLEN];
    logic [7:0]  pb1      [4][3];
    int          vcnt;
    int          idle1;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       sync;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    endtask

    function automatic logic [7:0] exp_byte(input int idx, input logic [12:0] p, input logic [3:0] c);
        case (idx)
            0:       return 8'h47;
            1:       return {3'b000, p[12:8]};
            2:       return p[7:0];
            3:       return {4'b0001, c};
            default: return 8'(idx - 4);
        endcase
    endfunction

    task automatic snap();
        o_data[0] = d0_data;  o_valid[0] = d0_valid; o_sync[0] = d0_sync;
        o_cc[0]   = d0_cc;    o_cnt[0]   = d0_cnt;
        o_data[1] = d1_data;  o_valid[1] = d1_valid; o_sync[1] = d1_sync;
        o_cc[1]   = d1_cc;    o_cnt[1]   = d1_cnt;
    endtask

    task automatic check_cycle();
        snap();
        if (o_valid[0] === 1'b1) vcnt++;
        if (o_valid[1] !== 1'b1) idle1++;
        for (int d = 0; d < 2; d++) begin
            chk("valid", d, o_valid[d], m_active[d]);
            if (m_active[d]) begin
                chk("data", d, o_data[d], exp_byte(m_idx[d], m_pid[d], m_cc[d]));
                chk("sync", d, o_sync[d], m_idx[d] == 0);
            end else begin
                chk("sync_idle", d, o_sync[d], 0);
            end
            chk("cc", d, o_cc[d], m_cc[d]);
            chk("count", d, o_cnt[d], m_count[d]);
        end
    endtask

    task automatic model_update();
        bit was_active;
        for (int d = 0; d < 2; d++) begin
`ifdef TS_CC_DROP_EN
            if (drop_req) m_pend[d] = 1'b1;
`endif
            was_active = m_active[d];
            if (was_active) begin
                if (ready) begin
                    if (d == 0) begin
                        cap[m_idx[0]]      = o_data[0];
                        cap_sync[m_idx[0]] = o_sync[0];
                    end
                    if (d == 1 && m_count[1] < 4 && m_idx[1] >= 1 && m_idx[1] <= 2)
                        pb1[m_count[1]][m_idx[1]] = o_data[1];
                    m_idx[d]++;
                    if (m_idx[d] == PLEN) begin
                        m_count[d]  = m_count[d] + 32'd1;
                        m_cc[d]     = m_cc[d] + (m_pend[d] ? 4'd2 : 4'd1);
                        m_pend[d]   = 1'b0;
                        m_active[d] = 1'b0;
                        m_idle[d]   = 0;
                        $display("pkt dut%0d n=%0d pid=%04h next_cc=%0d", d, m_count[d], m_pid[d], m_cc[d]);
                        if (GAPV[d] == 0 && enable) begin
                            m_active[d] = 1'b1; m_idx[d] = 0; m_pid[d] = pid;
                        end
                    end
                end
            end else begin
                m_idle[d]++;
                if (m_idle[d] >= GAPV[d] && enable) begin
                    m_active[d] = 1'b1; m_idx[d] = 0; m_pid[d] = pid;
                end
            end
        end
    endtask

    task automatic step(input logic en, input logic [12:0] p, input logic rdy, input logic drq);
        check_cycle();
        enable = en; pid = p; ready = rdy; drop_req = drq;
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; ready = 1'b1; drop_req = 1'b0;
        @(negedge clk);
        snap();
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", d, o_valid[d], 0);
            chk("rst_sync", d, o_sync[d], 0);
            chk("rst_data", d, o_data[d], 0);
            chk("rst_cc", d, o_cc[d], 0);
            chk("rst_count", d, o_cnt[d], 0);
            m_active[d] = 1'b0; m_idx[d] = 0; m_pid[d] = '0; m_cc[d] = '0;
            m_count[d] = '0; m_pend[d] = 1'b0; m_idle[d] = GAPV[d];
        end
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        int stall_left;
        bit stalled;
        logic rdy;
        logic drq;
        logic [12:0] rpid;
        logic [3:0] dcc [3];

        vecs[0] = '{0,   8'h47, 1'b1};
        vecs[1] = '{1,   8'h01, 1'b0};
        vecs[2] = '{2,   8'h00, 1'b0};
        vecs[3] = '{3,   8'h10, 1'b0};
        vecs[4] = '{4,   8'h00, 1'b0};
        vecs[5] = '{100, 8'h60, 1'b0};
        vecs[6] = '{187, 8'hB7, 1'b0};
`ifdef TS_CC_DROP_EN
        dcc = '{4'd7, 4'd8, 4'd9};
`else
        dcc = '{4'd6, 4'd7, 4'd8};
`endif
        reset = 1'b1; enable = 1'b0; pid = '0; ready = 1'b1; drop_req = 1'b0;
        vcnt = 0; idle1 = 0;
        @(negedge clk);

        // Basic start: one packet from a single enable pulse.
        do_reset();
        step(1'b1, 13'h0100, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++) step(1'b0, 13'h0100, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            chk("vec_data", 0, cap[vecs[i].idx], vecs[i].data);
            chk("vec_sync", 0, cap_sync[vecs[i].idx], vecs[i].sync);
        end
        snap();
        chk("basic_valid", 0, o_valid[0], 0);
        chk("basic_cc", 0, o_cc[0], 1);
        chk("basic_count", 0, o_cnt[0], 1);

        // Continuous run of 20 packets.
        do_reset();
        guard = 0;
        while (m_count[0] < 20 && guard < 20 * 200) begin
            step(1'b1, 13'h0ABC, 1'b1, 1'b0);
            guard++;
        end
        snap();
        chk("cont_count", 0, o_cnt[0], 20);
        chk("cont_cc", 0, o_cc[0], 4);
        for (int i = 0; i < 200; i++) step(1'b0, 13'h0ABC, 1'b1, 1'b0);

        // Backpressure: 3 stalled cycles at byte 3.
        do_reset();
        vcnt = 0; stalled = 0; stall_left = 0; guard = 0;
        step(1'b1, 13'h0155, 1'b1, 1'b0);
        while (m_count[0] < 1 && guard < 400) begin
            if (m_idx[0] == 3 && m_active[0] && !stalled) begin
                stall_left = 3; stalled = 1;
            end
            rdy = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            step(1'b0, 13'h0155, rdy, 1'b0);
            if (!rdy) begin
                snap();
                chk("bp_hold", 0, o_data[0], 8'h10);
                chk("bp_valid", 0, o_valid[0], 1);
            end
            guard++;
        end
        chk("bp_len", 0, vcnt, 191);
        for (int i = 0; i < 200; i++) step(1'b0, 13'h0155, 1'b1, 1'b0);

        // Drop injection during the cc=5 packet.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            while (m_count[0] < 6 + k && guard < 1500) begin
                drq = m_active[0] && m_cc[0] == 4'd5 && (m_idx[0] == 20 || m_idx[0] == 60);
                step(1'b1, 13'h0042, 1'b1, drq);
                guard++;
            end
            snap();
            chk("drop_cc", 0, o_cc[0], dcc[k]);
        end
        for (int i = 0; i < 200; i++) step(1'b0, 13'h0042, 1'b1, 1'b0);

        // Reset at byte 100 of the cc=2 packet.
        do_reset();
        guard = 0;
        while (!(m_active[0] && m_cc[0] == 4'd2 && m_idx[0] == 100) && guard < 1000) begin
            step(1'b1, 13'h0777, 1'b1, 1'b0);
            guard++;
        end
        chk("rst_mid_reached", 0, m_idx[0], 100);
        do_reset();
        step(1'b1, 13'h0777, 1'b1, 1'b0);
        snap();
        chk("rst_restart_sync", 0, o_sync[0], 1);
        guard = 0;
        while (m_count[0] < 1 && guard < 400) begin
            step(1'b0, 13'h0777, 1'b1, 1'b0);
            guard++;
        end
        snap();
        chk("rst_restart_cc", 0, o_cc[0], 1);
        for (int i = 0; i < 200; i++) step(1'b0, 13'h0777, 1'b1, 1'b0);

        // Back-to-back packets on dut1 with a PID change mid-packet.
        do_reset();
        rpid = 13'h0100;
        step(1'b1, rpid, 1'b1, 1'b0);
        idle1 = 0; guard = 0;
        while (m_count[1] < 2 && guard < 600) begin
            if (m_active[1] && m_idx[1] == 90) rpid = 13'h1FFF;
            step(1'b1, rpid, 1'b1, 1'b0);
            guard++;
        end
        chk("b2b_idle", 1, idle1, 0);
        chk("b2b_old_b1", 1, pb1[0][1], 8'h01);
        chk("b2b_old_b2", 1, pb1[0][2], 8'h00);
        chk("b2b_new_b1", 1, pb1[1][1], 8'h1F);
        chk("b2b_new_b2", 1, pb1[1][2], 8'hFF);
        for (int i = 0; i < 400; i++) step(1'b0, rpid, 1'b1, 1'b0);

        // Randomised traffic against the model.
        do_reset();
        rpid = 13'($urandom);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(199) == 0) rpid = 13'($urandom);
            step(($urandom_range(3) != 0), rpid, ($urandom_range(4) != 0),
                 ($urandom_range(39) == 0));
        end
        for (int i = 0; i < 500; i++) step(1'b0, rpid, 1'b1, 1'b0);
        snap();
        chk("rand_final_count0", 0, o_cnt[0], m_count[0]);
        chk("rand_final_count1", 1, o_cnt[1], m_count[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
